// File: rtl/fc_argmax.sv
// Fully-connected layer with ReLU and running argmax over N_CLASS classes, LANES MACs per beat.
// Optional FC_ARGMAX_SCORE_OUT_EN exposes the winning score on score_max while trmt is high.
module fc_argmax_lane #(
  parameter int DIN_W = 18,
  parameter int W_W   = 9
) (
  input  logic signed [DIN_W-1:0]     a_i,
  input  logic signed [W_W-1:0]       b_i,
  output logic signed [DIN_W+W_W-1:0] p_o
);
  assign p_o = a_i * b_i;
endmodule

module fc_argmax #(
  parameter int N_IN    = 64,
  parameter int LANES   = 16,
  parameter int N_CLASS = 10,
  parameter int DIN_W   = 18,
  parameter int W_W     = 9,
  parameter int B_W     = 9,
  localparam int BEATS  = N_IN / LANES,
  localparam int ACC_W  = DIN_W + W_W + $clog2(N_IN) + 1,
  localparam int AW     = (N_CLASS * BEATS > 1) ? $clog2(N_CLASS * BEATS) : 1,
  localparam int BW     = (BEATS > 1) ? $clog2(BEATS) : 1
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    strt,
  input  logic [N_IN*DIN_W-1:0]   din,
  output logic [AW-1:0]           w_addr,
  input  logic [LANES*W_W-1:0]    w_data,
  output logic [3:0]              b_addr,
  input  logic [B_W-1:0]          b_data,
  output logic                    busy,
  output logic                    trmt,
  input  logic                    tx_done,
  output logic [7:0]              dout
`ifdef FC_ARGMAX_SCORE_OUT_EN
  ,
  output logic [ACC_W-1:0]        score_max
`endif
);
  localparam logic [1:0] S_IDLE  = 2'd0;
  localparam logic [1:0] S_FETCH = 2'd1;
  localparam logic [1:0] S_MAC   = 2'd2;
  localparam logic [1:0] S_DONE  = 2'd3;

  logic [1:0]              state_q, state_d;
  logic [3:0]              class_q, class_d;
  logic [BW-1:0]           beat_q, beat_d;
  logic signed [ACC_W-1:0] acc_q, acc_d;
  logic signed [ACC_W-1:0] max_val_q, max_val_d;
  logic [3:0]              max_idx_q, max_idx_d;

  logic signed [DIN_W+W_W-1:0] prod [LANES];
  logic signed [ACC_W-1:0]     beat_sum, acc_nxt, score_raw, score;
  logic                        last_beat;
  logic [AW-1:0]               row_base;

  for (genvar l = 0; l < LANES; l++) begin : g_lane
    fc_argmax_lane #(.DIN_W(DIN_W), .W_W(W_W)) u_lane (
      .a_i (din[(int'(beat_q) * LANES + l) * DIN_W +: DIN_W]),
      .b_i (w_data[l * W_W +: W_W]),
      .p_o (prod[l])
    );
  end

  always_comb begin
    beat_sum = '0;
    for (int l = 0; l < LANES; l++) beat_sum = beat_sum + ACC_W'(prod[l]);
  end

  assign acc_nxt   = acc_q + beat_sum;
  assign score_raw = acc_nxt + ACC_W'(signed'(b_data));
  assign score     = score_raw[ACC_W-1] ? '0 : score_raw;
  assign last_beat = (beat_q == BW'(BEATS - 1));
  assign row_base  = AW'(class_q) * AW'(BEATS);

  always_comb begin
    state_d   = state_q;
    class_d   = class_q;
    beat_d    = beat_q;
    acc_d     = acc_q;
    max_val_d = max_val_q;
    max_idx_d = max_idx_q;
    case (state_q)
      S_IDLE: if (strt && !tx_done) begin
        state_d   = S_FETCH;
        class_d   = '0;
        beat_d    = '0;
        max_val_d = '0;
        max_idx_d = '0;
      end
      S_FETCH: begin
        acc_d   = '0;
        beat_d  = '0;
        state_d = S_MAC;
      end
      S_MAC: begin
        acc_d  = acc_nxt;
        beat_d = beat_q + BW'(1);
        if (last_beat) begin
          // strict compare keeps the lowest index on ties
          if (score > max_val_q) begin
            max_val_d = score;
            max_idx_d = class_q;
          end
          if (class_q < 4'(N_CLASS - 1)) begin
            class_d = class_q + 4'd1;
            state_d = S_FETCH;
          end else begin
            state_d = S_DONE;
          end
        end
      end
      default: ;
    endcase
    if (tx_done && state_q != S_IDLE) begin
      state_d   = S_IDLE;
      class_d   = '0;
      beat_d    = '0;
      acc_d     = '0;
      max_val_d = '0;
      max_idx_d = '0;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q   <= S_IDLE;
      class_q   <= '0;
      beat_q    <= '0;
      acc_q     <= '0;
      max_val_q <= '0;
      max_idx_q <= '0;
    end else begin
      state_q   <= state_d;
      class_q   <= class_d;
      beat_q    <= beat_d;
      acc_q     <= acc_d;
      max_val_q <= max_val_d;
      max_idx_q <= max_idx_d;
    end
  end

  // Weight RAM has one cycle of read latency, so MAC prefetches the next beat's row.
  always_comb begin
    case (state_q)
      S_FETCH: w_addr = row_base;
      S_MAC:   w_addr = row_base + AW'(beat_q) + (last_beat ? AW'(0) : AW'(1));
      default: w_addr = '0;
    endcase
  end

  assign b_addr = class_q;
  assign busy   = (state_q == S_FETCH) || (state_q == S_MAC);
  assign trmt   = (state_q == S_DONE);
  assign dout   = {4'h0, max_idx_q};

`ifdef FC_ARGMAX_SCORE_OUT_EN
  assign score_max = trmt ? ACC_W'(unsigned'(max_val_q)) : '0;
`endif
endmodule

// File: tb/tb_fc_argmax.sv
// Scoreboard bench for fc_argmax: a default instance and a small (32/8/4) instance.
module tb_fc_argmax;
  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  logic signed [17:0] dinv [64];
  logic signed [8:0]  wm   [64][16];
  logic signed [8:0]  bm   [16];

  logic              strt_b, tx_b, busy_b, trmt_b;
  logic [64*18-1:0]  din_b;
  logic [5:0]        w_addr_b;
  logic [16*9-1:0]   w_data_b;
  logic [3:0]        b_addr_b;
  logic [8:0]        b_data_b;
  logic [7:0]        dout_b;

  logic              strt_s, tx_s, busy_s, trmt_s;
  logic [32*18-1:0]  din_s;
  logic [3:0]        w_addr_s;
  logic [8*9-1:0]    w_data_s;
  logic [3:0]        b_addr_s;
  logic [8:0]        b_data_s;
  logic [7:0]        dout_s;

`ifdef FC_ARGMAX_SCORE_OUT_EN
  logic [33:0] score_b;
  logic [32:0] score_s;
`endif

  fc_argmax u_big (
    .clk(clk), .rst(rst), .strt(strt_b), .din(din_b), .w_addr(w_addr_b), .w_data(w_data_b),
    .b_addr(b_addr_b), .b_data(b_data_b), .busy(busy_b), .trmt(trmt_b), .tx_done(tx_b), .dout(dout_b)
`ifdef FC_ARGMAX_SCORE_OUT_EN
    , .score_max(score_b)
`endif
  );

  fc_argmax #(.N_IN(32), .LANES(8), .N_CLASS(4)) u_small (
    .clk(clk), .rst(rst), .strt(strt_s), .din(din_s), .w_addr(w_addr_s), .w_data(w_data_s),
    .b_addr(b_addr_s), .b_data(b_data_s), .busy(busy_s), .trmt(trmt_s), .tx_done(tx_s), .dout(dout_s)
`ifdef FC_ARGMAX_SCORE_OUT_EN
    , .score_max(score_s)
`endif
  );

  always_comb begin
    for (int k = 0; k < 64; k++) din_b[k*18 +: 18] = dinv[k];
  end
  always_comb begin
    for (int k = 0; k < 32; k++) din_s[k*18 +: 18] = dinv[k];
  end

  always @(posedge clk) begin
    for (int l = 0; l < 16; l++) w_data_b[l*9 +: 9] <= wm[w_addr_b][l];
    b_data_b <= bm[b_addr_b];
  end
  always @(posedge clk) begin
    for (int l = 0; l < 8; l++) w_data_s[l*9 +: 9] <= wm[w_addr_s][l];
    b_data_s <= bm[b_addr_s];
  end

  typedef struct { int idx; longint mx; int lat; } exp_t;
  exp_t sb[$];
  int checks = 0;
  int failures = 0;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s: got %0d expected %0d", tag, obs, exp);
    end
  endtask

  function automatic void model(input int nin, input int lanes, input int ncls,
                                output int idx, output longint mx);
    longint acc;
    int beats;
    beats = nin / lanes;
    idx = 0;
    mx = 0;
    for (int c = 0; c < ncls; c++) begin
      acc = longint'(bm[c]);
      for (int k = 0; k < nin; k++)
        acc += longint'(dinv[k]) * longint'(wm[c*beats + k/lanes][k%lanes]);
      if (acc < 0) acc = 0;
      if (acc > mx) begin mx = acc; idx = c; end
    end
  endfunction

  task automatic fill(input int dv, input int wv, input int bv);
    for (int k = 0; k < 64; k++) dinv[k] = 18'(dv);
    for (int a = 0; a < 64; a++) for (int l = 0; l < 16; l++) wm[a][l] = 9'(wv);
    for (int c = 0; c < 16; c++) bm[c] = 9'(bv);
  endtask

  task automatic weights_by_class(input int beats);
    for (int a = 0; a < 64; a++) for (int l = 0; l < 16; l++) wm[a][l] = 9'(a / beats);
  endtask

  task automatic randomize_all();
    for (int k = 0; k < 64; k++) dinv[k] = 18'($urandom);
    for (int a = 0; a < 64; a++) for (int l = 0; l < 16; l++) wm[a][l] = 9'($urandom);
    for (int c = 0; c < 16; c++) bm[c] = 9'($urandom);
  endtask

  // Caller must be positioned away from a clock edge; strt is sampled on the next edge.
  task automatic run_op(input bit sm, input bit poke, input string tag);
    exp_t e;
    int nin, lanes, ncls, n;
    logic [7:0] d;
    nin = sm ? 32 : 64;
    lanes = sm ? 8 : 16;
    ncls = sm ? 4 : 10;
    model(nin, lanes, ncls, e.idx, e.mx);
    e.lat = 1 + ncls * (nin / lanes + 1);
    sb.push_back(e);
    if (sm) strt_s = 1'b1; else strt_b = 1'b1;
    @(posedge clk); #1;
    strt_s = 1'b0; strt_b = 1'b0;
    n = 1;
    while (!(sm ? trmt_s : trmt_b) && n < 300) begin
      if (poke && n == 10) begin if (sm) strt_s = 1'b1; else strt_b = 1'b1; end
      @(posedge clk); #1;
      n++;
      strt_s = 1'b0; strt_b = 1'b0;
    end
    e = sb.pop_front();
    d = sm ? dout_s : dout_b;
    chk({tag, "_latency"}, 64'(n), 64'(e.lat));
    chk({tag, "_dout"}, 64'(d), 64'(e.idx));
    chk({tag, "_busy_in_done"}, 64'(sm ? busy_s : busy_b), 64'd0);
`ifdef FC_ARGMAX_SCORE_OUT_EN
    chk({tag, "_score_max"}, sm ? 64'(score_s) : 64'(score_b), 64'(e.mx));
`endif
    if (sm) tx_s = 1'b1; else tx_b = 1'b1;
    @(posedge clk); #1;
    tx_s = 1'b0; tx_b = 1'b0;
    chk({tag, "_trmt_release"}, 64'(sm ? trmt_s : trmt_b), 64'd0);
    chk({tag, "_dout_release"}, 64'(sm ? dout_s : dout_b), 64'd0);
`ifdef FC_ARGMAX_SCORE_OUT_EN
    chk({tag, "_score_idle"}, sm ? 64'(score_s) : 64'(score_b), 64'd0);
`endif
  endtask

  initial begin
    bit seen;
    strt_b = 0; tx_b = 0; strt_s = 0; tx_s = 0;
    fill(1, 0, 0);
    rst = 1'b1;
    #1;
    chk("rst_busy", 64'(busy_b), 64'd0);
    chk("rst_trmt", 64'(trmt_b), 64'd0);
    chk("rst_dout", 64'(dout_b), 64'd0);
    chk("rst_waddr", 64'(w_addr_b), 64'd0);
    chk("rst_baddr", 64'(b_addr_b), 64'd0);
    repeat (2) @(posedge clk);
    @(negedge clk) rst = 1'b0;

    // din=1, class c weights=c: class 9 wins; first edge after reset takes strt
    weights_by_class(4);
    run_op(1'b0, 1'b0, "byclass");

    // classes 3 and 7 tie at 100
    fill(1, 0, 0);
    for (int l = 0; l < 16; l++) for (int b = 0; b < 4; b++) begin
      wm[3*4 + b][l] = 9'sd1;
      wm[7*4 + b][l] = 9'sd1;
    end
    bm[3] = 9'sd36; bm[7] = 9'sd36;
    run_op(1'b0, 1'b0, "tie");

    fill(1, -1, 0);
    run_op(1'b0, 1'b0, "allneg");

    randomize_all();
    run_op(1'b0, 1'b1, "rand_poke");
    randomize_all();
    run_op(1'b0, 1'b0, "rand2");

    // extreme operands must not wrap the accumulator
    fill(18'h1FFFF, 9'h0FF, 0);
    run_op(1'b0, 1'b0, "maxval");
`ifdef FC_ARGMAX_SCORE_OUT_EN
    chk("maxval_model", 64'(sb.size()), 64'd0);
`endif

    // abort with tx_done in cycle 20
    fill(1, 0, 0);
    weights_by_class(4);
    strt_b = 1'b1;
    @(posedge clk); #1;
    strt_b = 1'b0;
    repeat (19) @(posedge clk);
    #1 tx_b = 1'b1;
    @(posedge clk); #1;
    tx_b = 1'b0;
    chk("abort_busy", 64'(busy_b), 64'd0);
    chk("abort_waddr", 64'(w_addr_b), 64'd0);
    seen = 1'b0;
    for (int i = 0; i < 60; i++) begin
      @(posedge clk); #1;
      if (trmt_b) seen = 1'b1;
    end
    chk("abort_no_trmt", 64'(seen), 64'd0);
    run_op(1'b0, 1'b0, "after_abort");

    // small instance: async reset mid-MAC, then a clean run
    randomize_all();
    strt_s = 1'b1;
    @(posedge clk); #1;
    strt_s = 1'b0;
    repeat (3) @(posedge clk);
    #2 rst = 1'b1;
    #1;
    chk("midrst_busy", 64'(busy_s), 64'd0);
    chk("midrst_trmt", 64'(trmt_s), 64'd0);
    chk("midrst_dout", 64'(dout_s), 64'd0);
    chk("midrst_waddr", 64'(w_addr_s), 64'd0);
    chk("midrst_baddr", 64'(b_addr_s), 64'd0);
    @(negedge clk) rst = 1'b0;
    run_op(1'b1, 1'b0, "small_rand");
    fill(1, 0, 0);
    weights_by_class(4);
    run_op(1'b1, 1'b1, "small_byclass");

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end
endmodule
